// File: rtl/eeprom_access_arbiter.sv
// eeprom_access_arbiter: round-robin sharing of one I2C EEPROM byte engine between two clients.
// Optional engine watchdog enabled by macro EE_ARB_TIMEOUT_EN. Rev 1.0.
`default_nettype none

module eeprom_access_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int NUM_W       = 6,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_req,
  input  logic              c1_req,
  input  logic              c0_wr,
  input  logic              c1_wr,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [NUM_W-1:0]  c0_num_sub1,
  input  logic [NUM_W-1:0]  c1_num_sub1,
  input  logic [7:0]        c0_wr_data,
  input  logic [7:0]        c1_wr_data,
  output logic              c0_grant,
  output logic              c1_grant,
  output logic              c0_done,
  output logic              c1_done,
  output logic [7:0]        c0_rd_data,
  output logic [7:0]        c1_rd_data,
  output logic              c0_rd_valid,
  output logic              c1_rd_valid,
  output logic              c0_wr_data_req,
  output logic              c1_wr_data_req,
  output logic              rd_byte_req,
  output logic              wr_byte_req,
  output logic [ADDR_W-1:0] byte_addr,
  output logic [NUM_W-1:0]  byte_num_sub1,
  output logic [7:0]        wr_byte_data,
  input  logic              wr_byte_data_req,
  input  logic [7:0]        rd_byte_data,
  input  logic              rd_byte_valid,
  input  logic              byte_busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              op_wr_q, op_wr_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              busy_prev_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic              winner;
  logic              busy_rise, busy_fall;
  logic              owned;
  logic              tmo_hit;

  assign busy_rise = byte_busy & ~busy_prev_q;
  assign busy_fall = ~byte_busy & busy_prev_q;

`ifdef EE_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;

  assign tmo_hit = ((state_q == S_ISSUE) || (state_q == S_BUSY)) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d         = cnt_q;
    timeout_err_d = tmo_hit;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if ((state_q == S_ISSUE) || (state_q == S_BUSY)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign tmo_hit            = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    op_wr_d  = op_wr_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    num_d    = num_q;
    winner   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (c0_req || c1_req) begin
          // Contention resolves to rr_ptr; a lone requester always wins.
          winner  = (c0_req && c1_req) ? rr_ptr_q : c1_req;
          sel_d   = winner;
          op_wr_d = winner ? c1_wr : c0_wr;
          addr_d  = winner ? c1_addr : c0_addr;
          num_d   = winner ? c1_num_sub1 : c0_num_sub1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tmo_hit)        state_d = S_DONE;
        else if (busy_rise) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (tmo_hit || busy_fall) state_d = S_DONE;
      end
      S_DONE: begin
        rr_ptr_d = ~sel_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      op_wr_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      busy_prev_q <= 1'b0;
      addr_q      <= '0;
      num_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      op_wr_q     <= op_wr_d;
      rr_ptr_q    <= rr_ptr_d;
      busy_prev_q <= byte_busy;
      addr_q      <= addr_d;
      num_q       <= num_d;
    end
  end

  // Ownership spans ISSUE..DONE, so engine strobes seen in IDLE reach nobody.
  assign owned          = (state_q != S_IDLE);
  assign c0_grant       = owned & ~sel_q;
  assign c1_grant       = owned & sel_q;
  assign c0_done        = (state_q == S_DONE) & ~sel_q;
  assign c1_done        = (state_q == S_DONE) & sel_q;
  assign rd_byte_req    = (state_q == S_ISSUE) & ~op_wr_q;
  assign wr_byte_req    = (state_q == S_ISSUE) & op_wr_q;
  assign byte_addr      = addr_q;
  assign byte_num_sub1  = num_q;
  assign wr_byte_data   = sel_q ? c1_wr_data : c0_wr_data;
  assign c0_rd_data     = rd_byte_data;
  assign c1_rd_data     = rd_byte_data;
  assign c0_rd_valid    = rd_byte_valid & c0_grant;
  assign c1_rd_valid    = rd_byte_valid & c1_grant;
  assign c0_wr_data_req = wr_byte_data_req & c0_grant;
  assign c1_wr_data_req = wr_byte_data_req & c1_grant;

endmodule

`default_nettype wire

// File: tb/tb_eeprom_access_arbiter.sv
// tb_eeprom_access_arbiter: directed and randomized bursts checked against a round-robin reference model.
`default_nettype none

module tb_eeprom_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, wr;
  logic [23:0] addr0, addr1;
  logic [5:0]  ns0, ns1;
  logic [7:0]  wd0, wd1;
  logic        wbdr, rvalid, busy;
  logic [7:0]  rbd;
  wire  [1:0]  grant, done, rdv, wdr;
  wire  [7:0]  rdd0, rdd1, wbd;
  wire         rd_req, wr_req, terr;
  wire  [23:0] baddr;
  wire  [5:0]  bnum;

  int passes = 0;
  int checks = 0;
  int rr_m   = 0;
  int strobes_seen = 0;
  int strobes_exp  = 0;

  always #5 clk = ~clk;

  eeprom_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req(req[0]), .c1_req(req[1]),
    .c0_wr(wr[0]), .c1_wr(wr[1]),
    .c0_addr(addr0), .c1_addr(addr1),
    .c0_num_sub1(ns0), .c1_num_sub1(ns1),
    .c0_wr_data(wd0), .c1_wr_data(wd1),
    .c0_grant(grant[0]), .c1_grant(grant[1]),
    .c0_done(done[0]), .c1_done(done[1]),
    .c0_rd_data(rdd0), .c1_rd_data(rdd1),
    .c0_rd_valid(rdv[0]), .c1_rd_valid(rdv[1]),
    .c0_wr_data_req(wdr[0]), .c1_wr_data_req(wdr[1]),
    .rd_byte_req(rd_req), .wr_byte_req(wr_req),
    .byte_addr(baddr), .byte_num_sub1(bnum),
    .wr_byte_data(wbd), .wr_byte_data_req(wbdr),
    .rd_byte_data(rbd), .rd_byte_valid(rvalid),
    .byte_busy(busy), .timeout_err(terr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: lone requester wins, contention goes to the round-robin pointer.
  function automatic int pick();
    if (req == 2'b11) return rr_m;
    return req[1] ? 1 : 0;
  endfunction

  task automatic set_client(input int who, input logic w, input logic [23:0] a, input logic [5:0] n);
    if (who == 1) begin wr[1] = w; addr1 = a; ns1 = n; end
    else          begin wr[0] = w; addr0 = a; ns0 = n; end
  endtask

  task automatic run_burst(input int who, input int delay, input bit hold, input bit mess_addr);
    logic        exp_wr;
    logic [23:0] exp_addr;
    logic [5:0]  exp_ns;
    logic [1:0]  oh;
    oh       = (who == 1) ? 2'b10 : 2'b01;
    exp_wr   = wr[who];
    exp_addr = (who == 1) ? addr1 : addr0;
    exp_ns   = (who == 1) ? ns1 : ns0;
    tick();
    check("grant", {30'd0, grant}, {30'd0, oh});
    check("byte_addr", {8'd0, baddr}, {8'd0, exp_addr});
    check("byte_num", {26'd0, bnum}, {26'd0, exp_ns});
    for (int i = 0; i <= delay; i++) begin
      check("eng_req_issue", {30'd0, wr_req, rd_req}, exp_wr ? 32'd2 : 32'd1);
      check("timeout_err_idle", {31'd0, terr}, 32'd0);
      if (i == delay) busy = 1'b1;
      tick();
    end
    check("eng_req_busy", {30'd0, wr_req, rd_req}, 32'd0);
    for (int k = 0; k <= int'(exp_ns); k++) begin
      if (mess_addr && k == 0) begin
        if (who == 1) begin addr1 = 24'hFFFFFF; ns1 = 6'($urandom); end
        else          begin addr0 = 24'hFFFFFF; ns0 = 6'($urandom); end
      end
      rbd = 8'($urandom);
      if (who == 1) wd1 = 8'($urandom); else wd0 = 8'($urandom);
      if (exp_wr) wbdr = 1'b1; else rvalid = 1'b1;
      strobes_exp++;
      #1;
      check("rd_valid_route", {30'd0, rdv}, exp_wr ? 32'd0 : {30'd0, oh});
      check("wr_req_route", {30'd0, wdr}, exp_wr ? {30'd0, oh} : 32'd0);
      check("rd_data_bcast", {16'd0, rdd1, rdd0}, {16'd0, rbd, rbd});
      if (exp_wr) check("wr_data_mux", {24'd0, wbd}, {24'd0, (who == 1) ? wd1 : wd0});
      check("byte_addr_hold", {8'd0, baddr}, {8'd0, exp_addr});
      if ((rdv | wdr) == oh) strobes_seen++;
      tick();
      wbdr = 1'b0; rvalid = 1'b0;
      if ($urandom_range(0, 2) == 0) tick();
    end
    busy = 1'b0;
    tick();
    check("done", {30'd0, done}, {30'd0, oh});
    check("grant_in_done", {30'd0, grant}, {30'd0, oh});
    if (!hold) req[who] = 1'b0;
    rr_m = 1 - who;
    tick();
    check("idle_grant", {30'd0, grant}, 32'd0);
    check("idle_done", {30'd0, done}, 32'd0);
    check("idle_eng_req", {30'd0, wr_req, rd_req}, 32'd0);
  endtask

  initial begin
    int w;
    rst_n = 1'b0; req = 2'b00; wr = 2'b00;
    addr0 = '0; addr1 = '0; ns0 = '0; ns1 = '0; wd0 = '0; wd1 = '0;
    wbdr = 1'b0; rvalid = 1'b0; busy = 1'b0; rbd = '0;
    tick(); tick();
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_done", {30'd0, done}, 32'd0);
    check("rst_eng_req", {30'd0, wr_req, rd_req}, 32'd0);
    check("rst_addr", {8'd0, baddr}, 32'd0);
    check("rst_num", {26'd0, bnum}, 32'd0);
    check("rst_err", {31'd0, terr}, 32'd0);
    rst_n = 1'b1;
    tick();

    // c0 read burst of 6 bytes.
    set_client(0, 1'b0, 24'h000100, 6'd5); req[0] = 1'b1;
    run_burst(pick(), 3, 1'b0, 1'b0);
    // c1 write burst of 4 bytes.
    set_client(1, 1'b1, 24'h00003F, 6'd3); req[1] = 1'b1;
    run_burst(pick(), 2, 1'b0, 1'b0);

    // Both held: alternation expected.
    set_client(0, 1'b0, 24'h000200, 6'd1);
    set_client(1, 1'b1, 24'h000300, 6'd2);
    req = 2'b11;
    for (int b = 0; b < 4; b++) begin
      check("rr_order", pick(), (b % 2 == 0) ? 32'd0 : 32'd1);
      run_burst(pick(), 1, (b < 3), 1'b0);
    end
    req = 2'b00;
    tick();

    // Address changed mid-burst must not reach the engine.
    set_client(0, 1'b0, 24'h000010, 6'd2); req[0] = 1'b1;
    run_burst(pick(), 1, 1'b0, 1'b1);

    // Engine strobes in IDLE are dropped.
    rvalid = 1'b1; wbdr = 1'b1; #1;
    check("idle_rd_valid", {30'd0, rdv}, 32'd0);
    check("idle_wr_req", {30'd0, wdr}, 32'd0);
    tick();
    rvalid = 1'b0; wbdr = 1'b0;

    // Reset during BUSY with rr_ptr pointing at c1.
    set_client(0, 1'b1, 24'h000555, 6'd4); req[0] = 1'b1;
    tick();
    check("pre_rst_grant", {30'd0, grant}, 32'd1);
    busy = 1'b1; tick(); tick();
    rst_n = 1'b0; tick();
    check("midrst_grant", {30'd0, grant}, 32'd0);
    check("midrst_eng_req", {30'd0, wr_req, rd_req}, 32'd0);
    check("midrst_done", {30'd0, done}, 32'd0);
    rst_n = 1'b1; busy = 1'b0; req = 2'b00; rr_m = 0;
    tick(); tick();
    set_client(0, 1'b0, 24'h000777, 6'd0);
    set_client(1, 1'b0, 24'h000888, 6'd0);
    req = 2'b11;
    check("post_rst_rr", pick(), 32'd0);
    run_burst(pick(), 0, 1'b0, 1'b0);
    run_burst(pick(), 0, 1'b0, 1'b0);

    // Engine slow to start: request held, no watchdog in this build.
    set_client(1, 1'b0, 24'h000999, 6'd1); req[1] = 1'b1;
    run_burst(pick(), 150, 1'b0, 1'b0);

    // Randomized requests, fields and engine timing.
    for (int it = 0; it < 12; it++) begin
      w = int'($urandom_range(1, 3));
      for (int c = 0; c < 2; c++) begin
        if (w[c] && !req[c]) begin
          set_client(c, 1'($urandom), 24'($urandom), 6'($urandom_range(0, 15)));
          req[c] = 1'b1;
        end
      end
      run_burst(pick(), int'($urandom_range(0, 4)), 1'b0, 1'($urandom));
    end
    req = 2'b00;
    tick();
    check("strobe_total", strobes_seen, strobes_exp);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
